slc3_input_conditioner: RTL and testbench

SLC3_INPUT_CONDITIONER -- requirements
Module: slc3_input_conditioner

---
 rtl/slc3_input_conditioner.sv | 130 +++++++++++++
 tb/tb_slc3_input_conditioner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_input_conditioner.sv
// rtl/slc3_input_conditioner.sv - synchronizes/debounces slc3 board inputs; combo-reset FSM under SLC3_COMBO_RESET_EN
module slc3_input_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] COMBO_CYCLES    = 24'd5000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_n,
  input  logic       Continue_n,
  input  logic [9:0] SW_raw,
  output logic       Run,
  output logic       Continue,
  output logic       Run_pulse,
  output logic       Continue_pulse,
  output logic [9:0] SW,
  output logic       Cpu_Reset
);

  // index 0 = Run, index 1 = Continue; sync flops carry the raw active-low level
  logic [1:0]  btn_s1, btn_s2;
  logic [1:0]  pressed_s;
  logic [1:0]  stable, stable_d;
  logic [15:0] db_cnt [2];
  logic [9:0]  sw_s1;
  logic [1:0]  rise;
  logic        suppress;
  logic        combo_hold;

  assign pressed_s = ~btn_s2;
  assign rise      = stable & ~stable_d;
  assign Run       = stable[0];
  assign Continue  = stable[1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_s1    <= 2'b11;
      btn_s2    <= 2'b11;
      sw_s1     <= '0;
      SW        <= '0;
      stable    <= '0;
      stable_d  <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      btn_s1   <= {Continue_n, Run_n};
      btn_s2   <= btn_s1;
      sw_s1    <= SW_raw;
      SW       <= sw_s1;
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (pressed_s[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Run_pulse      <= 1'b0;
      Continue_pulse <= 1'b0;
    end else begin
      Run_pulse      <= rise[0] & ~suppress;
      Continue_pulse <= rise[1] & ~suppress;
    end
  end

  always_ff @(posedge Clk) begin
    Cpu_Reset <= Reset | combo_hold;
  end

`ifdef SLC3_COMBO_RESET_EN
  typedef enum logic [1:0] {IDLE, ARMING, RESET_HOLD} combo_state_t;

  combo_state_t state, state_next;
  logic [23:0]  combo_cnt, combo_cnt_next;
  logic         both_pressed;

  assign both_pressed = Run & Continue;
  assign suppress     = (state == RESET_HOLD);
  assign combo_hold   = (state == RESET_HOLD);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      combo_cnt <= '0;
    end else begin
      state     <= state_next;
      combo_cnt <= combo_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    combo_cnt_next = combo_cnt;
    case (state)
      IDLE: begin
        if (both_pressed) begin
          state_next     = ARMING;
          combo_cnt_next = '0;
        end
      end
      ARMING: begin
        // release is tested first so it wins over the terminal count
        if (!both_pressed) begin
          state_next = IDLE;
        end else begin
          combo_cnt_next = combo_cnt + 24'd1;
          if ({1'b0, combo_cnt} + 25'd1 >= {1'b0, COMBO_CYCLES} - 25'd1)
            state_next = RESET_HOLD;
        end
      end
      RESET_HOLD: begin
        if (!Run && !Continue)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
`else
  assign suppress   = 1'b0;
  assign combo_hold = 1'b0;
`endif

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// tb/tb_slc3_input_conditioner.sv - directed bench for slc3_input_conditioner (DEBOUNCE_CYCLES=4, COMBO_CYCLES=8)
module tb_slc3_input_conditioner;

`ifdef SLC3_COMBO_RESET_EN
  localparam bit COMBO_EN = 1'b1;
`else
  localparam bit COMBO_EN = 1'b0;
`endif

  logic       Clk;
  logic       Reset;
  logic       Run_n;
  logic       Continue_n;
  logic [9:0] SW_raw;
  logic       Run;
  logic       Continue;
  logic       Run_pulse;
  logic       Continue_pulse;
  logic [9:0] SW;
  logic       Cpu_Reset;

  int checks = 0;
  int errors = 0;

  slc3_input_conditioner #(
    .DEBOUNCE_CYCLES(16'd4),
    .COMBO_CYCLES   (24'd8)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Run_n         (Run_n),
    .Continue_n    (Continue_n),
    .SW_raw        (SW_raw),
    .Run           (Run),
    .Continue      (Continue),
    .Run_pulse     (Run_pulse),
    .Continue_pulse(Continue_pulse),
    .SW            (SW),
    .Cpu_Reset     (Cpu_Reset)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Run_n = 1'b1; Continue_n = 1'b1; SW_raw = 10'h3FF;
    tick(3);
    checks++;
    if ({Run, Continue, Run_pulse, Continue_pulse, SW, Cpu_Reset} !== {4'b0000, 10'h000, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", {Run, Continue, Run_pulse, Continue_pulse, SW, Cpu_Reset}, {4'b0000, 10'h000, 1'b1});
    end
    Reset = 1'b0;
    tick(1);
    checks++;
    if (Cpu_Reset !== 1'b0 || SW !== 10'h000) begin
      errors++;
      $display("FAIL reset_release got cpu=%b sw=%h exp cpu=0 sw=000", Cpu_Reset, SW);
    end
    tick(1);
    checks++;
    if (SW !== 10'h3FF) begin
      errors++;
      $display("FAIL sw_sync got %h exp 3ff", SW);
    end
    SW_raw = 10'h2A5;
    tick(1);
    checks++;
    if (SW !== 10'h3FF) begin
      errors++;
      $display("FAIL sw_latency1 got %h exp 3ff", SW);
    end
    tick(1);
    checks++;
    if (SW !== 10'h2A5) begin
      errors++;
      $display("FAIL sw_latency2 got %h exp 2a5", SW);
    end
  endtask

  task automatic test_single_press;
    Run_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      checks++;
      if (Run !== (k >= 6) || Run_pulse !== (k == 7) || Continue_pulse !== 1'b0) begin
        errors++;
        $display("FAIL press k=%0d got run=%b rp=%b cp=%b exp run=%b rp=%b cp=0", k, Run, Run_pulse, Continue_pulse, k >= 6, k == 7);
      end
    end
    Run_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      checks++;
      if (Run !== (k < 6) || Run_pulse !== 1'b0) begin
        errors++;
        $display("FAIL release k=%0d got run=%b rp=%b exp run=%b rp=0", k, Run, Run_pulse, k < 6);
      end
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 10; i++) begin
      Run_n = i[0];
      for (int j = 0; j < 2; j++) begin
        tick(1);
        checks++;
        if (Run !== 1'b0 || Run_pulse !== 1'b0) begin
          errors++;
          $display("FAIL bounce seg=%0d got run=%b rp=%b exp 0 0", i, Run, Run_pulse);
        end
      end
    end
    Run_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      checks++;
      if (Run !== (k >= 6) || Run_pulse !== (k == 7)) begin
        errors++;
        $display("FAIL bounce_settle k=%0d got run=%b rp=%b exp run=%b rp=%b", k, Run, Run_pulse, k >= 6, k == 7);
      end
    end
    Run_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset_midway;
    Run_n = 1'b0;
    tick(4);
    Reset = 1'b1;
    Run_n = 1'b1;
    tick(2);
    checks++;
    if (Run !== 1'b0 || Run_pulse !== 1'b0 || Cpu_Reset !== 1'b1) begin
      errors++;
      $display("FAIL midreset got run=%b rp=%b cpu=%b exp 0 0 1", Run, Run_pulse, Cpu_Reset);
    end
    Reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      checks++;
      if (Run !== 1'b0 || Run_pulse !== 1'b0 || Cpu_Reset !== 1'b0) begin
        errors++;
        $display("FAIL midreset_after k=%0d got run=%b rp=%b cpu=%b exp 0 0 0", k, Run, Run_pulse, Cpu_Reset);
      end
    end
  endtask

  task automatic test_combo_reset;
    Run_n = 1'b0; Continue_n = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      checks++;
      if (Run !== (k >= 6) || Continue !== (k >= 6) || Run_pulse !== (k == 7) ||
          Continue_pulse !== (k == 7) || Cpu_Reset !== (COMBO_EN && k >= 15)) begin
        errors++;
        $display("FAIL combo_hold k=%0d got run=%b cont=%b rp=%b cp=%b cpu=%b exp run=%b cont=%b rp=%b cp=%b cpu=%b",
                 k, Run, Continue, Run_pulse, Continue_pulse, Cpu_Reset,
                 k >= 6, k >= 6, k == 7, k == 7, COMBO_EN && k >= 15);
      end
    end
    Run_n = 1'b1; Continue_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick(1);
      checks++;
      if (Run !== (j < 6) || Continue !== (j < 6) || Run_pulse !== 1'b0 ||
          Continue_pulse !== 1'b0 || Cpu_Reset !== (COMBO_EN && j < 8)) begin
        errors++;
        $display("FAIL combo_release j=%0d got run=%b cont=%b rp=%b cp=%b cpu=%b exp run=%b cont=%b rp=0 cp=0 cpu=%b",
                 j, Run, Continue, Run_pulse, Continue_pulse, Cpu_Reset, j < 6, j < 6, COMBO_EN && j < 8);
      end
    end
  endtask

  task automatic test_combo_abort;
    Run_n = 1'b0; Continue_n = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick(1);
      checks++;
      if (Run !== (k >= 6) || Continue !== (k >= 6 && k < 13) || Run_pulse !== (k == 7) ||
          Continue_pulse !== (k == 7) || Cpu_Reset !== 1'b0) begin
        errors++;
        $display("FAIL combo_abort k=%0d got run=%b cont=%b rp=%b cp=%b cpu=%b exp run=%b cont=%b rp=%b cp=%b cpu=0",
                 k, Run, Continue, Run_pulse, Continue_pulse, Cpu_Reset,
                 k >= 6, k >= 6 && k < 13, k == 7, k == 7);
      end
      // debounced Continue falls exactly as the combo counter hits its terminal value
      if (k == 7) Continue_n = 1'b1;
    end
    Run_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      checks++;
      if (Run !== (k < 6) || Run_pulse !== 1'b0 || Cpu_Reset !== 1'b0) begin
        errors++;
        $display("FAIL combo_abort_release k=%0d got run=%b rp=%b cpu=%b exp run=%b rp=0 cpu=0", k, Run, Run_pulse, Cpu_Reset, k < 6);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Run_n = 1'b1; Continue_n = 1'b1; SW_raw = 10'h000;
    test_reset();
    test_single_press();
    test_bounce();
    test_reset_midway();
    test_combo_reset();
    test_combo_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
